// File: rtl/flag_unit.sv
// ---------------------------------------------------------------------------
// flag_unit
//   Reader side of the ALU flag interface. Holds the architectural NZCV
//   register, counts flag-setting ops that are in flight between ID and EX,
//   and evaluates branch conditions against the newest architectural flags.
//   A branch is never resolved against stale flags: while an older
//   flag-setting op is still in flight the branch is stalled.
//
// Parameters
//   MAX_INFLIGHT : max flag-setting ops in flight between issue and write
//   FORWARD      : 1 = a flag write in the same cycle bypasses into the
//                  condition evaluation (flags and pending count)
//
// Ports
//   clk, reset   : clock; asynchronous active-high reset
//   negative, zero, overflow, carryOut : ALU flags from EX
//   flagWe       : flag-setting op completes this cycle, latch ALU flags
//   flagIssue    : flag-setting op issued this cycle (enters flight)
//   condReq      : branch requests a condition evaluation this cycle
//   cond         : 4-bit condition code
//   condValid    : condTaken is valid this cycle
//   condTaken    : condition true (0 whenever condValid is 0)
//   stall        : condReq && !condValid, ID must hold the branch
//   flags        : architectural {N,Z,C,V}
//   err          : sticky protocol error (issue overflow / write underflow)
//   pending      : debug view of the in-flight counter
//
// Request/response handshake
//   condReq acts as "valid" from ID and condValid as the same-cycle "ready"
//   response. A request is consumed only in a cycle where condReq and
//   condValid are both high; otherwise stall is high and ID must present the
//   same branch (condReq high, cond stable) again next cycle. There is no
//   buffering: the answer is purely combinational on the current state.
// ---------------------------------------------------------------------------
module flag_unit #(
    parameter int MAX_INFLIGHT = 3,
    parameter bit FORWARD      = 1'b1,
    localparam int PW          = (MAX_INFLIGHT < 1) ? 1 : $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          negative,
    input  logic          zero,
    input  logic          overflow,
    input  logic          carryOut,
    input  logic          flagWe,
    input  logic          flagIssue,
    input  logic          condReq,
    input  logic [3:0]    cond,
    output logic          condValid,
    output logic          condTaken,
    output logic          stall,
    output logic [3:0]    flags,
    output logic          err,
    output logic [PW-1:0] pending
);

    // Condition encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_INFLIGHT);
    localparam logic [PW-1:0] PEND_ONE = PW'(1);

    // Evaluate a condition code against an {N,Z,C,V} vector.
    // 1110 (AL) and 1111 both fall to the default and are always true.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_HS: r = cf;
            COND_LO: r = ~cf;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = cf & ~z;
            COND_LS: r = ~cf | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [3:0]    flags_q;
    logic [PW-1:0] pend_q;
    logic          err_q;

    logic [3:0]    flags_d;
    logic [PW-1:0] pend_d;
    logic          err_d;

    logic [3:0]    alu_flags;
    logic          issue_only;
    logic          we_only;
    logic          at_max;
    logic          at_zero;

    assign alu_flags  = {negative, zero, carryOut, overflow};
    assign issue_only = flagIssue & ~flagWe;
    assign we_only    = flagWe & ~flagIssue;
    assign at_max     = (pend_q == PEND_MAX);
    assign at_zero    = (pend_q == '0);

    // Flag register: every completing op writes, even when the counter
    // reports a protocol error in the same cycle.
    always_comb begin
        flags_d = flags_q;
        if (flagWe) begin
            flags_d = alu_flags;
        end
    end

    // In-flight counter. Issue and write in the same cycle cancel out.
    // Over/underflow saturates and raises the sticky error instead.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (issue_only) begin
            if (at_max) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (we_only) begin
            if (at_zero) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Effective state seen by the branch this cycle.
    // A flag write landing now already counts as retired when forwarding is
    // on. A flagIssue in the same cycle is younger than the branch, so it is
    // deliberately not part of the effective pending count.
    // ---------------------------------------------------------------------
    logic [3:0]    eff_flags;
    logic [PW-1:0] eff_pend;

    always_comb begin
        eff_flags = flags_q;
        eff_pend  = pend_q;
        if (FORWARD && flagWe) begin
            eff_flags = alu_flags;
            eff_pend  = at_zero ? '0 : (pend_q - PEND_ONE);
        end
    end

    // ---------------------------------------------------------------------
    // Branch-side outputs
    // ---------------------------------------------------------------------
    logic eff_clear;

    assign eff_clear = (eff_pend == '0);

    always_comb begin
        condValid = 1'b0;
        condTaken = 1'b0;
        stall     = 1'b0;
        if (condReq) begin
            condValid = eff_clear;
            stall     = ~eff_clear;
            condTaken = eff_clear & cond_eval(cond, eff_flags);
        end
    end

    assign flags   = flags_q;
    assign err     = err_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       negative, zero, overflow, carryOut;
  logic       flagWe, flagIssue, condReq;
  logic [3:0] cond;
  logic       condValid, condTaken, stall, err;
  logic [3:0] flags;
  logic [1:0] pending;

  always #5 clk = ~clk;

  flag_unit #(.MAX_INFLIGHT(3), .FORWARD(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carryOut  (carryOut),
    .flagWe    (flagWe),
    .flagIssue (flagIssue),
    .condReq   (condReq),
    .cond      (cond),
    .condValid (condValid),
    .condTaken (condTaken),
    .stall     (stall),
    .flags     (flags),
    .err       (err),
    .pending   (pending)
  );

  // ------------------------------------------------------------------
  // Scoreboard
  // ------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after posedge)
  // ------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    negative  = 1'b0;
    zero      = 1'b0;
    overflow  = 1'b0;
    carryOut  = 1'b0;
    flagWe    = 1'b0;
    flagIssue = 1'b0;
    condReq   = 1'b0;
    cond      = 4'b0000;
  endtask

  task automatic drive_alu(input logic [3:0] nzcv);
    negative = nzcv[3];
    zero     = nzcv[2];
    carryOut = nzcv[1];
    overflow = nzcv[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Vector table: flags to latch, condition, expected taken
  // ------------------------------------------------------------------
  typedef struct {
    logic [3:0] nzcv;
    logic [3:0] cond;
    logic       taken;
  } vec_t;

  vec_t vecs[24];

  initial begin
    // overflow add 7FFF..F + 1: N=1 Z=0 C=0 V=1
    vecs[0]  = '{4'b1001, 4'b1010, 1'b1};  // GE: N==V
    vecs[1]  = '{4'b1001, 4'b1011, 1'b0};  // LT
    vecs[2]  = '{4'b1001, 4'b0100, 1'b1};  // MI
    vecs[3]  = '{4'b1001, 4'b0010, 1'b0};  // HS
    vecs[4]  = '{4'b1001, 4'b0110, 1'b1};  // VS
    // -12 + 12: N=0 Z=1 C=1 V=0
    vecs[5]  = '{4'b0110, 4'b0000, 1'b1};  // EQ
    vecs[6]  = '{4'b0110, 4'b0010, 1'b1};  // HS
    vecs[7]  = '{4'b0110, 4'b1000, 1'b0};  // HI
    vecs[8]  = '{4'b0110, 4'b1001, 1'b1};  // LS
    vecs[9]  = '{4'b0110, 4'b1100, 1'b0};  // GT
    vecs[10] = '{4'b0110, 4'b1101, 1'b1};  // LE
    // all clear
    vecs[11] = '{4'b0000, 4'b0001, 1'b1};  // NE
    vecs[12] = '{4'b0000, 4'b0011, 1'b1};  // LO
    vecs[13] = '{4'b0000, 4'b0101, 1'b1};  // PL
    vecs[14] = '{4'b0000, 4'b0111, 1'b1};  // VC
    vecs[15] = '{4'b0000, 4'b1110, 1'b1};  // AL
    vecs[16] = '{4'b0000, 4'b1111, 1'b1};  // 1111 acts as AL
    vecs[17] = '{4'b0000, 4'b1100, 1'b1};  // GT
    // mixed
    vecs[18] = '{4'b0010, 4'b1000, 1'b1};  // HI: C & !Z
    vecs[19] = '{4'b1000, 4'b1100, 1'b0};  // GT with N!=V
    vecs[20] = '{4'b1000, 4'b1101, 1'b1};  // LE with N!=V
    vecs[21] = '{4'b0001, 4'b1011, 1'b1};  // LT with V only
    vecs[22] = '{4'b1111, 4'b0000, 1'b1};  // EQ
    vecs[23] = '{4'b1111, 4'b0001, 1'b0};  // NE
  end

  // ------------------------------------------------------------------
  // Test sequence
  // ------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    drive_idle();
    next_cycle();
    @(negedge clk);
    chk("rst_flags",   {4'b0, flags},   8'h00);
    chk("rst_pending", {6'b0, pending}, 8'h00);
    chk("rst_err",     {7'b0, err},     8'h00);
    next_cycle();
    reset = 1'b0;

    // 1: after reset, EQ against 0000 evaluates immediately, not taken
    condReq = 1'b1;
    cond    = 4'b0000;
    @(negedge clk);
    chk("t1_valid", {7'b0, condValid}, 8'h01);
    chk("t1_taken", {7'b0, condTaken}, 8'h00);
    chk("t1_stall", {7'b0, stall},     8'h00);
    chk("t1_flags", {4'b0, flags},     8'h00);
    next_cycle();
    drive_idle();

    // Table: issue+write same cycle keeps pending at 0 (no error); the
    // written flags are forwarded, then read back from the register.
    for (int i = 0; i < 24; i++) begin
      drive_alu(vecs[i].nzcv);
      flagIssue = 1'b1;
      flagWe    = 1'b1;
      condReq   = 1'b1;
      cond      = vecs[i].cond;
      @(negedge clk);
      chk($sformatf("vec%0d_fwd_valid", i), {7'b0, condValid}, 8'h01);
      chk($sformatf("vec%0d_fwd_taken", i), {7'b0, condTaken}, {7'b0, vecs[i].taken});
      exp_q.push_back(vecs[i].nzcv);
      next_cycle();
      // ALU inputs now inverted: result must come from the register
      drive_alu(~vecs[i].nzcv);
      flagIssue = 1'b0;
      flagWe    = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_reg_taken", i), {7'b0, condTaken}, {7'b0, vecs[i].taken});
      chk($sformatf("vec%0d_flags", i), {4'b0, flags}, {4'b0, exp_q.pop_front()});
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    chk("tbl_pending", {6'b0, pending}, 8'h00);
    chk("tbl_err",     {7'b0, err},     8'h00);
    next_cycle();

    // condReq together with flagIssue: the issue is younger, no stall
    flagIssue = 1'b1;
    condReq   = 1'b1;
    cond      = 4'b1110;
    @(negedge clk);
    chk("young_valid", {7'b0, condValid}, 8'h01);
    chk("young_stall", {7'b0, stall},     8'h00);
    next_cycle();
    // op now in flight; condReq low must not stall
    drive_idle();
    @(negedge clk);
    chk("noreq_stall", {7'b0, stall},     8'h00);
    chk("noreq_valid", {7'b0, condValid}, 8'h00);
    chk("noreq_pend",  {6'b0, pending},   8'h01);
    next_cycle();
    // retire it
    flagWe = 1'b1;
    next_cycle();
    drive_idle();

    // 2: issue, stall, forwarded write resolves in the same cycle
    flagIssue = 1'b1;
    next_cycle();
    drive_idle();
    condReq = 1'b1;
    cond    = 4'b0001;
    @(negedge clk);
    chk("t2_stall",   {7'b0, stall},     8'h01);
    chk("t2_valid0",  {7'b0, condValid}, 8'h00);
    chk("t2_taken0",  {7'b0, condTaken}, 8'h00);
    next_cycle();
    flagWe = 1'b1;
    drive_alu(4'b0100);
    @(negedge clk);
    chk("t2_valid1",  {7'b0, condValid}, 8'h01);
    chk("t2_taken1",  {7'b0, condTaken}, 8'h00);
    chk("t2_stall1",  {7'b0, stall},     8'h00);
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("t2_flags",   {4'b0, flags},   8'h04);
    chk("t2_pending", {6'b0, pending}, 8'h00);
    chk("t2_err",     {7'b0, err},     8'h00);
    next_cycle();

    // 5: overflow the in-flight counter
    for (int i = 0; i < 4; i++) begin
      flagIssue = 1'b1;
      next_cycle();
      @(negedge clk);
      if (i == 2) chk("t5_err_at3", {7'b0, err}, 8'h00);
      #1;
    end
    drive_idle();
    @(negedge clk);
    chk("t5_pend_sat", {6'b0, pending}, 8'h03);
    chk("t5_err",      {7'b0, err},     8'h01);
    next_cycle();
    flagIssue = 1'b1;
    flagWe    = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("t5_pend_both", {6'b0, pending}, 8'h03);
    next_cycle();
    condReq = 1'b1;
    cond    = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      flagWe = 1'b1;
      @(negedge clk);
      chk($sformatf("t5_stall_we%0d", i), {7'b0, stall}, (i == 2) ? 8'h00 : 8'h01);
      next_cycle();
    end
    flagWe = 1'b0;
    @(negedge clk);
    chk("t5_pend_zero", {6'b0, pending},   8'h00);
    chk("t5_stall_clr", {7'b0, stall},     8'h00);
    chk("t5_valid",     {7'b0, condValid}, 8'h01);
    chk("t5_err_stick", {7'b0, err},       8'h01);
    next_cycle();
    drive_idle();

    // Underflow write at pending 0: error, flags still written
    do_reset();
    flagWe = 1'b1;
    drive_alu(4'b1111);
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("uf_err",     {7'b0, err},     8'h01);
    chk("uf_pending", {6'b0, pending}, 8'h00);
    chk("uf_flags",   {4'b0, flags},   8'h0f);
    next_cycle();

    // 6: asynchronous reset in the middle of a stall
    flagIssue = 1'b1;
    next_cycle();
    next_cycle();
    flagIssue = 1'b0;
    condReq   = 1'b1;
    cond      = 4'b0000;
    @(negedge clk);
    chk("t6_stall_pre", {7'b0, stall},   8'h01);
    chk("t6_pend_pre",  {6'b0, pending}, 8'h02);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_stall",   {7'b0, stall},     8'h00);
    chk("t6_valid",   {7'b0, condValid}, 8'h01);
    chk("t6_taken",   {7'b0, condTaken}, 8'h00);
    chk("t6_flags",   {4'b0, flags},     8'h00);
    chk("t6_err",     {7'b0, err},       8'h00);
    chk("t6_pending", {6'b0, pending},   8'h00);
    next_cycle();
    reset = 1'b0;
    drive_idle();
    next_cycle();

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
